// File: rtl/counter_pkg.sv
// Shared constants and serializer state encoding for the BCD counter chain.
package counter_pkg;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    SER_IDLE     = 2'd0,
    SER_SHIFT_LO = 2'd1,
    SER_SHIFT_HI = 2'd2,
    SER_LATCH    = 2'd3
  } ser_state_e;
endpackage

// File: rtl/bcd_digit.sv
// One decimal digit: +1 on inc, wraps 9 -> 0 and flags a carry in that same cycle.
module bcd_digit
  import counter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [BCD_W-1:0] value,
  output logic             carry
);
  logic [BCD_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (inc) value_d = (value_q == BCD_MAX) ? '0 : value_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) value_q <= '0;
    else       value_q <= value_d;
  end

  assign value = value_q;
  assign carry = inc && (value_q == BCD_MAX);
endmodule

// File: rtl/bcd_counter_chain.sv
// Multi-digit BCD counter with one-digit-per-clock carry ripple, plus a
// snapshot register that is shifted out MSB first to an external display.
module bcd_counter_chain
  import counter_pkg::*;
#(
  parameter int DIGITS  = 6,
  parameter int SER_DIV = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DIGITS-1:0]       trigger,
  input  logic                    inc_clk,
  input  logic                    ref_clk,
  output logic [BCD_W*DIGITS-1:0] count_bcd,
  output logic [BCD_W*DIGITS-1:0] disp_bcd,
  output logic                    busy,
  output logic                    overflow,
  output logic                    ser_data,
  output logic                    ser_clk,
  output logic                    ser_latch
);
  localparam int FRAME_W = BCD_W * DIGITS;
  localparam int POS_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = (SER_DIV > 1) ? $clog2(SER_DIV) : 1;
  localparam logic [POS_W-1:0] TOP_POS  = POS_W'(DIGITS - 1);
  localparam logic [BIT_W-1:0] TOP_BIT  = BIT_W'(FRAME_W - 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SER_DIV - 1);

  logic [DIGITS-1:0] inc, carry;
  logic [BCD_W-1:0]  digit_val [DIGITS];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .reset (reset),
      .inc   (inc[g]),
      .value (digit_val[g]),
      .carry (carry[g])
    );
    assign count_bcd[g*BCD_W +: BCD_W] = digit_val[g];
  end

  logic             busy_q, busy_d, ovf_q, ovf_d, act;
  logic [POS_W-1:0] pos_q, pos_d, sel_pos, act_pos;

  // A pending carry owns the chain; new requests are only accepted when idle.
  always_comb begin
    sel_pos = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (trigger[k]) sel_pos = POS_W'(k);
    end
    act     = busy_q | (inc_clk & (|trigger));
    act_pos = busy_q ? pos_q : sel_pos;
    inc     = '0;
    if (act) inc[act_pos] = 1'b1;
  end

  always_comb begin
    busy_d = busy_q;
    pos_d  = pos_q;
    ovf_d  = ovf_q;
    if (act) begin
      if (carry[act_pos]) begin
        if (act_pos == TOP_POS) begin
          ovf_d  = 1'b1;
          busy_d = 1'b0;
        end else begin
          busy_d = 1'b1;
          pos_d  = act_pos + 1'b1;
        end
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  ser_state_e         state_q, state_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [FRAME_W-1:0] disp_q, disp_d;
  logic               ser_data_q, ser_data_d, ser_clk_q, ser_clk_d, ser_latch_q, ser_latch_d;

  // Outputs are registered copies of what the next state implies.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    div_d   = div_q;
    disp_d  = disp_q;
    if (ref_clk) begin
      disp_d  = count_bcd;
      state_d = SER_SHIFT_LO;
      bit_d   = TOP_BIT;
      div_d   = DIV_LOAD;
    end else begin
      unique case (state_q)
        SER_IDLE: ;
        SER_SHIFT_LO: begin
          if (div_q == '0) begin
            state_d = SER_SHIFT_HI;
            div_d   = DIV_LOAD;
          end else begin
            div_d = div_q - 1'b1;
          end
        end
        SER_SHIFT_HI: begin
          if (div_q == '0) begin
            div_d = DIV_LOAD;
            if (bit_q == '0) begin
              state_d = SER_LATCH;
            end else begin
              bit_d   = bit_q - 1'b1;
              state_d = SER_SHIFT_LO;
            end
          end else begin
            div_d = div_q - 1'b1;
          end
        end
        SER_LATCH: state_d = SER_IDLE;
      endcase
    end
    ser_clk_d   = (state_d == SER_SHIFT_HI);
    ser_data_d  = ((state_d == SER_SHIFT_LO) || (state_d == SER_SHIFT_HI)) && disp_d[bit_d];
    ser_latch_d = (state_d == SER_LATCH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q      <= 1'b0;
      pos_q       <= '0;
      ovf_q       <= 1'b0;
      state_q     <= SER_IDLE;
      bit_q       <= '0;
      div_q       <= '0;
      disp_q      <= '0;
      ser_data_q  <= 1'b0;
      ser_clk_q   <= 1'b0;
      ser_latch_q <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      pos_q       <= pos_d;
      ovf_q       <= ovf_d;
      state_q     <= state_d;
      bit_q       <= bit_d;
      div_q       <= div_d;
      disp_q      <= disp_d;
      ser_data_q  <= ser_data_d;
      ser_clk_q   <= ser_clk_d;
      ser_latch_q <= ser_latch_d;
    end
  end

  assign busy      = busy_q;
  assign overflow  = ovf_q;
  assign disp_bcd  = disp_q;
  assign ser_data  = ser_data_q;
  assign ser_clk   = ser_clk_q;
  assign ser_latch = ser_latch_q;
endmodule

// File: doc/bcd_counter_chain.md
Name: bcd_counter_chain

Overview:
- Downstream consumer of the debounced trigger pulses.
- Holds a DIGITS-wide BCD count. Each `inc_clk` pulse adds 1 at the digit selected by the trigger inputs, and the carry ripples one digit per clock.
- On each `ref_clk` pulse it snapshots the settled count into a display register and shifts it out serially to an external display shift register.

Parameters:
- DIGITS, 6, number of BCD digits. This is also the width of `trigger`.
- SER_DIV, 1, half-period of `ser_clk` in `clk` cycles.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- trigger  in  DIGITS  raw digit-select inputs; bit k selects digit k (k=0 is the least significant digit)
- inc_clk  in  1  one-cycle increment pulse from the trigger stage
- ref_clk  in  1  one-cycle refresh pulse from the trigger stage
- count_bcd  out  4*DIGITS  live count; digit k is bits [4k+3:4k]
- disp_bcd  out  4*DIGITS  snapshot of the count taken on the last refresh
- busy  out  1  high while a carry is still propagating
- overflow  out  1  sticky; set when the top digit wraps from 9 to 0
- ser_data  out  1  serial data, MSB first
- ser_clk  out  1  serial shift clock
- ser_latch  out  1  one-cycle latch strobe sent after the last bit

Behaviour:
- Reset (asynchronous, active-high): all outputs are 0, every digit is 0, the serializer is idle, and the carry position is cleared. Reset in the middle of a carry or a shift aborts the operation immediately with no further output.
- Increment request:
  - On a cycle where `inc_clk`=1 and `busy`=0, `trigger` is sampled.
  - Selected digit k is the lowest set bit of `trigger`.
  - If `trigger`==0, nothing happens.
  - If `inc_clk`=1 while `busy`=1, the request is ignored.
- Digit update:
  - At the next edge, digit k becomes (digit+1) mod 10.
  - If digit k was 9, a carry is pending into digit k+1 and `busy` goes to 1.
- Carry ripple:
  - Each following edge applies +1 to the next digit, with the same wrap and carry rule.
  - When a +1 produces no carry, `busy` drops to 0 at that edge.
  - Worst case (digit 0 selected, all digits 9): the last digit updates at T+DIGITS, where T is the `inc_clk` cycle. The upstream stage asserts `ref_clk` no earlier than T+6, so with DIGITS<=6 the snapshot always sees a settled count.
- Overflow:
  - A carry out of digit DIGITS-1 wraps that digit to 0, ends the ripple and sets `overflow`.
  - `overflow` stays set until reset.
- Digit values are always in 0..9; there is no path that produces A..F.
- Refresh:
  - On `ref_clk`=1, `disp_bcd` is loaded with `count_bcd` at the next edge.
  - The serializer starts shifting `disp_bcd` out, MSB first (bit 4*DIGITS-1 first).
  - If `ref_clk` arrives while a shift is in progress, `disp_bcd` reloads and the shift restarts from the MSB. No `ser_latch` is issued for the aborted frame.
- Serializer FSM, states IDLE, SHIFT_LO, SHIFT_HI, LATCH:
  - SHIFT_LO: `ser_data` is driven with the current bit and `ser_clk`=0, for SER_DIV cycles.
  - SHIFT_HI: `ser_clk`=1 for SER_DIV cycles. The bit counter then decrements and the FSM returns to SHIFT_LO, or goes to LATCH after bit 0.
  - LATCH: `ser_latch`=1 for one cycle, then IDLE.
  - Frame length: 4*DIGITS*2*SER_DIV cycles plus the LATCH cycle.
  - `ser_data` and `ser_clk` are 0 in IDLE.
- `inc_clk` and `ref_clk` in the same cycle: the increment starts, and the snapshot takes the pre-increment count.
- All outputs are registered.

Decomposition:
- Shared package (counter_pkg):
  - `BCD_W`=4
  - `BCD_MAX`=4'd9
  - serializer state encodings for IDLE, SHIFT_LO, SHIFT_HI, LATCH
- One natural sub-module, bcd_digit, instantiated DIGITS times:
  - inputs: clk, reset, inc
  - outputs: 4-bit value, carry
  - carry is asserted when inc arrives with value==9
- The ripple sequencing and the serializer stay in the top-level module.

Test Plan:
- Reset, then trigger=6'b000001 with one `inc_clk` pulse -> `count_bcd`=24'h000001 one cycle later; `busy` stays 0.
- Count 24'h000009, trigger=6'b000001, one `inc_clk` pulse -> digit0=0 at T+1 and digit1=1 at T+2; `busy`=1 only during T+1; final count 24'h000010.
- Count 24'h999999, trigger bit0, one `inc_clk` pulse -> 24'h000000 at T+6; `overflow`=1, and it stays 1 after further increments until reset.
- Count 24'h000095:
  - trigger=6'b000100 -> 24'h000195.
  - trigger=6'b001100 -> lowest set bit is digit 2, so 24'h000295.
  - trigger=0 -> no change.
  - an `inc_clk` pulse arriving while `busy`=1 -> ignored.
- Count 24'h123456, one `ref_clk` pulse, SER_DIV=1 -> `disp_bcd`=24'h123456 the next cycle; 24 `ser_clk` rising edges carry 0001_0010_0011_0100_0101_0110; `ser_latch` pulses once, 49 cycles after the start of the shift.
- Mid-shift cases:
  - `ref_clk` re-asserted mid-shift -> the shift restarts from the MSB and only one `ser_latch` is issued.
  - Reset asserted mid-shift -> all outputs are 0 immediately.
